// File: rtl/eth_pkg.sv
// Shared Ethernet constants, receive FSM state type and the reflected CRC-32 byte step.
package eth_pkg;

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} rx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        return c;
    endfunction

endpackage

// File: rtl/axis_if.sv
// AXI4-Stream style byte channel with a bad-frame flag on tuser.
interface axis_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_crc32.sv
// Byte-wide Ethernet CRC-32 register (no final XOR); init has priority over enable.
module eth_crc32 import eth_pkg::*; (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    always_ff @(posedge clk_i) begin
        if (!rstn_i || init_i)
            crc_o <= CRC_INIT;
        else if (en_i)
            crc_o <= crc32_byte(crc_o, data_i);
    end

endmodule

// File: rtl/gmii_frame_rx.sv
// GMII receive framer: strips preamble/SFD and FCS, checks the CRC residue and streams
// the payload out with a 5-byte lag; no backpressure reaches the PHY, stalls become overflow.
module gmii_frame_rx import eth_pkg::*; #(
    parameter int DATA_WIDTH   = 8,
    parameter bit CRC_CHECK_EN = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    input  logic                  rx_dv_i,
    input  logic                  rx_er_i,
    axis_if.master                m_axis,
    output logic                  frame_ok_o,
    output logic                  crc_err_o,
    output logic                  overflow_o,
    output logic                  runt_o
);

    rx_state_e                        state;
    logic [3:0][DATA_WIDTH-1:0]       dline;
    logic [2:0]                       dl_cnt;
    logic [DATA_WIDTH-1:0]            hold;
    logic                             hold_vld;
    logic                             frame_err;
    logic                             armed;
    logic [DATA_WIDTH-1:0]            tdata_q;
    logic                             tvalid_q;
    logic                             tlast_q;
    logic                             tuser_q;
    logic [31:0]                      crc;

    logic sfd_hit, byte_in, crc_bad, beat_busy;

    assign sfd_hit   = (state == PREAMBLE) && rx_dv_i && !rx_er_i && (rx_data_i == SFD_BYTE);
    assign byte_in   = (state == PAYLOAD) && rx_dv_i;
    assign crc_bad   = CRC_CHECK_EN && (crc != CRC_RESIDUE);
    assign beat_busy = tvalid_q && !m_axis.tready;

    eth_crc32 u_crc (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .init_i (sfd_hit),
        .en_i   (byte_in),
        .data_i (rx_data_i),
        .crc_o  (crc)
    );

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tuser  = tuser_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            dl_cnt     <= 3'd0;
            hold_vld   <= 1'b0;
            frame_err  <= 1'b0;
            armed      <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
            frame_ok_o <= 1'b0;
            crc_err_o  <= 1'b0;
            overflow_o <= 1'b0;
            runt_o     <= 1'b0;
        end else begin
            frame_ok_o <= 1'b0;
            crc_err_o  <= 1'b0;
            overflow_o <= 1'b0;
            runt_o     <= 1'b0;
            if (tvalid_q && m_axis.tready)
                tvalid_q <= 1'b0;

            case (state)
                // armed stays low after reset until dv is seen low, so a frame cut by reset is ignored
                IDLE: begin
                    if (!rx_dv_i)
                        armed <= 1'b1;
                    else if (armed && rx_data_i == PREAMBLE_BYTE)
                        state <= PREAMBLE;
                end
                PREAMBLE: begin
                    if (!rx_dv_i)
                        state <= IDLE;
                    else if (rx_er_i)
                        state <= DROP;
                    else if (rx_data_i == SFD_BYTE) begin
                        state     <= PAYLOAD;
                        dl_cnt    <= 3'd0;
                        hold_vld  <= 1'b0;
                        frame_err <= 1'b0;
                    end else if (rx_data_i != PREAMBLE_BYTE)
                        state <= DROP;
                end
                PAYLOAD: begin
                    if (rx_dv_i) begin
                        if (rx_er_i)
                            frame_err <= 1'b1;
                        dline <= {dline[2:0], rx_data_i};
                        if (dl_cnt == 3'd4) begin
                            hold     <= dline[3];
                            hold_vld <= 1'b1;
                            if (hold_vld) begin
                                if (beat_busy) begin
                                    overflow_o <= 1'b1;
                                    tlast_q    <= 1'b1;
                                    tuser_q    <= 1'b1;
                                    hold_vld   <= 1'b0;
                                    state      <= DROP;
                                end else begin
                                    tvalid_q <= 1'b1;
                                    tdata_q  <= hold;
                                    tlast_q  <= 1'b0;
                                    tuser_q  <= 1'b0;
                                end
                            end
                        end else
                            dl_cnt <= dl_cnt + 3'd1;
                    end else begin
                        // hold only fills on the 5th byte, so an empty hold means a runt
                        state    <= IDLE;
                        hold_vld <= 1'b0;
                        if (!hold_vld)
                            runt_o <= 1'b1;
                        else if (beat_busy) begin
                            overflow_o <= 1'b1;
                            tlast_q    <= 1'b1;
                            tuser_q    <= 1'b1;
                        end else begin
                            tvalid_q   <= 1'b1;
                            tdata_q    <= hold;
                            tlast_q    <= 1'b1;
                            tuser_q    <= crc_bad || frame_err;
                            frame_ok_o <= !(crc_bad || frame_err);
                            crc_err_o  <= crc_bad;
                        end
                    end
                end
                DROP: begin
                    if (!rx_dv_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
